// File: rtl/hex_scan_controller.sv
// hex_scan_controller
//   Time-multiplexes NUM_DIGITS hex digits onto one shared hex-to-7-segment
//   decoder. Each digit gets a BLANK gap (all digits dark) followed by a SHOW
//   dwell. Displayed contents are double-buffered: a load is held pending and
//   copied into the active buffer only at a frame boundary, or immediately
//   while the display is disabled.
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   disp_en     1 = scan running, 0 = dark and parked at BLANK(0)
//   load        1-cycle request to update display contents
//   load_value  digit k nibble at [4k+3:4k]
//   load_dots   digit k dot request, 1 = on
//   load_ack    1-cycle pulse after new contents become active
//   hex_nibble  nibble to the shared decoder
//   hex_dot     dot to the decoder, active-low
//   digit_en_n  active-low digit enables, at most one low
module hex_scan_controller #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned DWELL_CYCLES = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    disp_en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   input  logic [NUM_DIGITS-1:0]   load_dots,
   output logic                    load_ack,
   output logic [3:0]              hex_nibble,
   output logic                    hex_dot,
   output logic [NUM_DIGITS-1:0]   digit_en_n
);

   localparam int unsigned VW   = 4 * NUM_DIGITS;
   localparam int unsigned TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);
   localparam int unsigned IW   = $clog2(NUM_DIGITS);

   localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
   localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] idx, idx_nxt;
   logic [TW-1:0] timer, timer_nxt;

   logic                  pending, pending_nxt;
   logic [VW-1:0]         pend_value;
   logic [NUM_DIGITS-1:0] pend_dots;
   logic [VW-1:0]         act_value, act_value_nxt;
   logic [NUM_DIGITS-1:0] act_dots, act_dots_nxt;

   logic                  frame_end;
   logic                  xfer;
   logic [3:0]            nibble_nxt;
   logic                  dot_nxt;
   logic [NUM_DIGITS-1:0] en_nxt;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_BLANK;
         idx   <= '0;
         timer <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         timer <= timer_nxt;
      end
   end

   // Next-state: BLANK -> SHOW -> BLANK(next digit); disable parks at BLANK(0)
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      timer_nxt = timer + TW'(1);
      if (!disp_en) begin
         state_nxt = ST_BLANK;
         idx_nxt   = '0;
         timer_nxt = '0;
      end else begin
         case (state)
            ST_BLANK: begin
               if (timer == BLANK_LAST) begin
                  state_nxt = ST_SHOW;
                  timer_nxt = '0;
               end
            end
            ST_SHOW: begin
               if (timer == DWELL_LAST) begin
                  state_nxt = ST_BLANK;
                  timer_nxt = '0;
                  idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
               end
            end
            default: begin
               state_nxt = ST_BLANK;
               idx_nxt   = '0;
               timer_nxt = '0;
            end
         endcase
      end
   end

   // Buffer transfer: at the edge leaving SHOW(N-1), or any cycle while dark.
   // A load on the transfer cycle bypasses the pending buffer.
   always_comb begin
      frame_end     = disp_en && (state == ST_SHOW) && (idx == IDX_LAST) && (timer == DWELL_LAST);
      xfer          = (pending || load) && (frame_end || !disp_en);
      act_value_nxt = act_value;
      act_dots_nxt  = act_dots;
      pending_nxt   = pending;
      if (xfer) begin
         act_value_nxt = load ? load_value : pend_value;
         act_dots_nxt  = load ? load_dots  : pend_dots;
         pending_nxt   = 1'b0;
      end else if (load) begin
         pending_nxt   = 1'b1;
      end
   end

   // Output decode from the next state; nibble/dot only refresh while blanked
   always_comb begin
      en_nxt     = '1;
      nibble_nxt = hex_nibble;
      dot_nxt    = hex_dot;
      if (state_nxt == ST_BLANK) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_nxt == IW'(k)) begin
               nibble_nxt = act_value_nxt[4*k +: 4];
               dot_nxt    = ~act_dots_nxt[k];
            end
         end
      end else begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_nxt == IW'(k)) begin
               en_nxt[k] = 1'b0;
            end
         end
      end
   end

   // Buffers and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending    <= 1'b0;
         pend_value <= '0;
         pend_dots  <= '0;
         act_value  <= '0;
         act_dots   <= '0;
         load_ack   <= 1'b0;
         hex_nibble <= 4'h0;
         hex_dot    <= 1'b1;
         digit_en_n <= '1;
      end else begin
         pending    <= pending_nxt;
         if (load) begin
            pend_value <= load_value;
            pend_dots  <= load_dots;
         end
         act_value  <= act_value_nxt;
         act_dots   <= act_dots_nxt;
         load_ack   <= xfer;
         hex_nibble <= nibble_nxt;
         hex_dot    <= dot_nxt;
         digit_en_n <= en_nxt;
      end
   end

endmodule
